dmem_arbiter: RTL and testbench

- Shares the single-port data memory between the processor's load/store path and an external requester: debug/loader or future DMA.
- Sits between the processor control outputs (mem_read/mem_write, ALU-result address, rt write data) and the data memory.
- Drives cpu_stall, which the processor uses to hold PC and suppress register write while a load is in flight or the CPU loses arbitration.
- Fixed CPU priority, with a starvation guard that guarantees the external port a grant.

---
 rtl/dmem_arb_pkg.sv | 17 +
 rtl/dmem_starve_ctr.sv | 34 +++
 rtl/dmem_arbiter.sv | 129 ++++++++++++
 tb/tb_dmem_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned AW_DEF = 9;
  localparam int unsigned DW_DEF = 32;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_EXT = 1'b1
  } owner_e;

endpackage

// File: rtl/dmem_starve_ctr.sv
// Saturating count of consecutive cycles the external requester was refused.
module dmem_starve_ctr #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          clr,
  input  logic [CW-1:0] limit,
  output logic          at_limit,
  output logic [CW-1:0] cnt
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != limit))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign at_limit = (cnt_q == limit);
  assign cnt      = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU load/store path vs. external requester,
// fixed CPU priority with a starvation guard for the external port.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW           = AW_DEF,
  parameter int unsigned DW           = DW_DEF,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_mem_read,
  input  logic          cpu_mem_write,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_gnt,
  output logic          ext_rvalid,
  output logic [DW-1:0] ext_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [DW-1:0] cpu_rdata_q, ext_rdata_q;
  logic          cpu_req, ext_win, at_limit;
  logic          cpu_rd_ret, ext_rd_ret;
  logic [3:0]    wait_cnt;

  assign cpu_req = cpu_mem_read | cpu_mem_write;
  assign ext_win = ext_req & (at_limit | ~cpu_req);

  dmem_starve_ctr #(.CW(4)) u_starve (
    .clk      (clk),
    .reset    (reset),
    .inc      (ext_req & ~ext_gnt),
    .clr      (ext_gnt),
    .limit    (LIMIT),
    .at_limit (at_limit),
    .cnt      (wait_cnt)
  );

  // Everything is gated by reset so no strobe escapes while reset is held,
  // and a read return pending at reset is silently discarded.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ext_gnt    = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = cpu_addr;
    mem_wdata  = cpu_wdata;
    cpu_stall  = 1'b0;
    cpu_rd_ret = 1'b0;
    ext_rd_ret = 1'b0;
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          if (ext_win) begin
            ext_gnt   = 1'b1;
            mem_en    = 1'b1;
            mem_we    = ext_we;
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
            cpu_stall = cpu_req;
            if (!ext_we) begin
              state_d = RD_WAIT;
              owner_d = OWN_EXT;
            end
          end else if (cpu_req) begin
            mem_en = 1'b1;
            mem_we = cpu_mem_write;
            if (!cpu_mem_write) begin
              cpu_stall = 1'b1;
              state_d   = RD_WAIT;
              owner_d   = OWN_CPU;
            end
          end
        end
        RD_WAIT: begin
          state_d = IDLE;
          if (owner_q == OWN_CPU) begin
            cpu_rd_ret = 1'b1;
          end else begin
            ext_rd_ret = 1'b1;
            cpu_stall  = cpu_req;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      if (cpu_rd_ret) cpu_rdata_q <= mem_rdata;
      if (ext_rd_ret) ext_rdata_q <= mem_rdata;
    end
  end

  assign cpu_rdata  = cpu_rd_ret ? mem_rdata : cpu_rdata_q;
  assign ext_rdata  = ext_rd_ret ? mem_rdata : ext_rdata_q;
  assign ext_rvalid = ext_rd_ret;

  always_ff @(posedge clk) begin
    if (!reset)
      assert (!(cpu_mem_read && cpu_mem_write))
        else $warning("dmem_arbiter: cpu_mem_read and cpu_mem_write both set, store issued");
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a registered-read memory model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_mem_read, cpu_mem_write;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          ext_req, ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata, ext_rdata;
  logic          ext_gnt, ext_rvalid;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and leave time for new inputs to settle before the checks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Expected cpu_stall / ext_gnt while a CPU load and ext read are both held.
  logic exp_stall [0:4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic exp_gnt   [0:4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    for (int unsigned i = 0; i < (1<<AW); i++) mem[i] = '0;
    mem_rdata = '0;
    reset = 1'b1;
    cpu_mem_read = 1'b1; cpu_mem_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
    tick(); settle();
    check_eq("rst_stall",  32'(cpu_stall),  32'd0);
    check_eq("rst_mem_en", 32'(mem_en),     32'd0);
    check_eq("rst_gnt",    32'(ext_gnt),    32'd0);
    check_eq("rst_rvalid", 32'(ext_rvalid), 32'd0);
    tick();
    reset = 1'b0; cpu_mem_read = 1'b0; ext_req = 1'b0;
    settle();
    check_eq("rst_cnt", 32'(dut.wait_cnt), 32'd0);

    // CPU store then load of addr 5
    cpu_mem_write = 1'b1; cpu_addr = 9'd5; cpu_wdata = 32'hDEADBEEF;
    settle();
    check_eq("st_en",    32'(mem_en),    32'd1);
    check_eq("st_we",    32'(mem_we),    32'd1);
    check_eq("st_stall", 32'(cpu_stall), 32'd0);
    check_eq("st_addr",  32'(mem_addr),  32'd5);
    tick();
    cpu_mem_write = 1'b0; cpu_mem_read = 1'b1;
    settle();
    check_eq("ld_stall", 32'(cpu_stall), 32'd1);
    check_eq("ld_we",    32'(mem_we),    32'd0);
    tick(); settle();
    check_eq("ld_ret_stall", 32'(cpu_stall), 32'd0);
    check_eq("ld_ret_data",  cpu_rdata,      32'hDEADBEEF);
    check_eq("ld_no_reissue", 32'(mem_en),   32'd0);
    tick();
    cpu_mem_read = 1'b0;
    settle();
    check_eq("ld_hold", cpu_rdata, 32'hDEADBEEF);

    // Ext write then read of addr 10
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 9'd10; ext_wdata = 32'h1234;
    settle();
    check_eq("ew_gnt", 32'(ext_gnt), 32'd1);
    check_eq("ew_we",  32'(mem_we),  32'd1);
    tick();
    ext_we = 1'b0;
    settle();
    check_eq("er_gnt", 32'(ext_gnt),    32'd1);
    check_eq("er_we",  32'(mem_we),     32'd0);
    check_eq("er_rv0", 32'(ext_rvalid), 32'd0);
    tick();
    ext_req = 1'b0;
    settle();
    check_eq("er_rvalid", 32'(ext_rvalid), 32'd1);
    check_eq("er_rdata",  ext_rdata,       32'h1234);
    tick(); settle();
    check_eq("er_rv_low", 32'(ext_rvalid), 32'd0);
    check_eq("er_hold",   ext_rdata,       32'h1234);

    // Starvation guard: CPU load held, ext read held
    cpu_mem_read = 1'b1; cpu_addr = 9'd5; ext_req = 1'b1; ext_we = 1'b0; ext_addr = 9'd10;
    for (int k = 0; k < 5; k++) begin
      settle();
      check_eq($sformatf("sv_stall%0d", k), 32'(cpu_stall), 32'(exp_stall[k]));
      check_eq($sformatf("sv_gnt%0d", k),   32'(ext_gnt),   32'(exp_gnt[k]));
      tick();
    end
    ext_req = 1'b0;
    settle();
    check_eq("sv_rvalid", 32'(ext_rvalid),   32'd1);
    check_eq("sv_rdata",  ext_rdata,         32'h1234);
    check_eq("sv_stall5", 32'(cpu_stall),    32'd1);
    check_eq("sv_cnt0",   32'(dut.wait_cnt), 32'd0);
    tick(); settle();
    check_eq("sv_cpu_iss", 32'(mem_en),    32'd1);
    check_eq("sv_cpu_stl", 32'(cpu_stall), 32'd1);
    tick(); settle();
    check_eq("sv_cpu_data", cpu_rdata, 32'hDEADBEEF);
    tick();

    // Simultaneous CPU load and ext read with wait_cnt == 0
    cpu_mem_read = 1'b1; cpu_addr = 9'd5; ext_req = 1'b1; ext_we = 1'b0; ext_addr = 9'd10;
    settle();
    check_eq("tie_cnt",   32'(dut.wait_cnt), 32'd0);
    check_eq("tie_stall", 32'(cpu_stall),    32'd1);
    check_eq("tie_gnt",   32'(ext_gnt),      32'd0);
    check_eq("tie_addr",  32'(mem_addr),     32'd5);
    tick(); settle();
    check_eq("tie_ret",   cpu_rdata,         32'hDEADBEEF);
    check_eq("tie_gnt1",  32'(ext_gnt),      32'd0);
    tick();
    cpu_mem_read = 1'b0;
    settle();
    check_eq("tie_egnt",  32'(ext_gnt),  32'd1);
    check_eq("tie_eaddr", 32'(mem_addr), 32'd10);
    tick();

    // Reset in the RD_WAIT cycle of an ext read
    ext_req = 1'b0; reset = 1'b1;
    settle();
    check_eq("rrd_rvalid", 32'(ext_rvalid), 32'd0);
    tick();
    reset = 1'b0;
    settle();
    check_eq("rrd_state",  32'(dut.state_q),  32'(IDLE));
    check_eq("rrd_cnt",    32'(dut.wait_cnt), 32'd0);
    check_eq("rrd_mem_en", 32'(mem_en),       32'd0);
    check_eq("rrd_rv2",    32'(ext_rvalid),   32'd0);
    tick();

    // Illegal read+write: the store wins
    cpu_mem_read = 1'b1; cpu_mem_write = 1'b1; cpu_addr = 9'd20; cpu_wdata = 32'hA5A5A5A5;
    settle();
    check_eq("rw_we",    32'(mem_we),    32'd1);
    check_eq("rw_stall", 32'(cpu_stall), 32'd0);
    tick();
    cpu_mem_write = 1'b0;
    settle();
    check_eq("rw_ld_stall", 32'(cpu_stall), 32'd1);
    tick(); settle();
    check_eq("rw_ld_data", cpu_rdata, 32'hA5A5A5A5);
    tick();
    cpu_mem_read = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
